// File: rtl/rom_detect_pkg.sv
// rom_detect_pkg: mapper codes, FSM states and size/opcode constants shared by the ROM mapper detector.
package rom_detect_pkg;
    localparam logic [3:0] MAP_UNKNOWN    = 4'd0;
    localparam logic [3:0] MAP_NONE       = 4'd1;
    localparam logic [3:0] MAP_GM2        = 4'd2;
    localparam logic [3:0] MAP_KONAMI     = 4'd3;
    localparam logic [3:0] MAP_KONAMI_SCC = 4'd4;
    localparam logic [3:0] MAP_ASCII8     = 4'd5;
    localparam logic [3:0] MAP_ASCII16    = 4'd6;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL1, S_EVAL2, S_DONE} state_t;

    localparam logic [7:0] OP_LD   = 8'h32;
    localparam logic [7:0] OP_ZERO = 8'h00;

    localparam int SZ_4K  = 32'h1000;
    localparam int SZ_8K  = 32'h2000;
    localparam int SZ_16K = 32'h4000;
    localparam int SZ_32K = 32'h8000;
    localparam int SZ_48K = 32'hC000;
    localparam int SZ_64K = 32'h10000;

    function automatic logic is_ab(input logic [7:0] b0, input logic [7:0] b1);
        return b0 == 8'h41 && b1 == 8'h42;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: signed up/down counter that clamps at its extremes instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic signed [W-1:0] q
);
    localparam logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE = 1;

    always_ff @(posedge clk) begin
        if (reset || clear)
            q <= '0;
        else if (inc && !dec && q != MAX)
            q <= q + ONE;
        else if (dec && !inc && q != MIN)
            q <= q - ONE;
    end
endmodule

// File: rtl/rom_mapper_detect.sv
// rom_mapper_detect: classifies an MSX cartridge image while it streams into memory,
// then runs a two-cycle evaluation producing mapper code, start page offset and size.
module rom_mapper_detect import rom_detect_pkg::*; #(
    parameter int              ADDR_W  = 25,
    parameter int              CNT_W   = 16,
    parameter logic [ADDR_W-1:0] GM2_MIN = 25'h18000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic              busy,
    output logic              valid,
    output logic [3:0]        mapper,
    output logic [3:0]        offset,
    output logic [ADDR_W-1:0] rom_size
);
    localparam logic [ADDR_W-1:0] Z4K  = ADDR_W'(SZ_4K);
    localparam logic [ADDR_W-1:0] Z8K  = ADDR_W'(SZ_8K);
    localparam logic [ADDR_W-1:0] Z16K = ADDR_W'(SZ_16K);
    localparam logic [ADDR_W-1:0] Z32K = ADDR_W'(SZ_32K);
    localparam logic [ADDR_W-1:0] Z48K = ADDR_W'(SZ_48K);
    localparam logic [ADDR_W-1:0] Z64K = ADDR_W'(SZ_64K);

    state_t state;
    logic load_q;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0] win1, win0;
    logic [7:0] head [4];
    logic [7:0] head2 [4];
    logic [1:0] h5, h25;
    logic game1, game2, sig0, sig4;
    logic [15:0] start, start4k;
    logic signed [CNT_W-1:0] asc8, asc16, kon4, kon5, kon, ascii;
    logic rise, fall, we, contig, hit;
    logic a16_inc, a16_dec, k4_inc, k5_inc;
    logic [3:0] map_nx, off_nx, off_small, off_32k;

    assign rise    = load && !load_q;
    assign fall    = !load && load_q;
    assign we      = state == S_LOAD && wr;
    assign contig  = addr == prev_addr + 1'b1;
    // The byte being written completes the window 32,00,X only if it follows the previous one
    assign hit     = we && contig && win1 == OP_LD && win0 == OP_ZERO;
    assign a16_inc = hit && (data == 8'h60 || data == 8'h70);
    assign a16_dec = hit && (data == 8'h68 || data == 8'h78);
    assign k4_inc  = hit && (data == 8'h60 || data == 8'h80 || data == 8'hA0);
    assign k5_inc  = hit && (data == 8'h50 || data == 8'h70 || data == 8'h90 || data == 8'hB0);
    assign busy    = state == S_LOAD || state == S_EVAL1 || state == S_EVAL2;

    sat_counter #(.W(CNT_W)) u_asc8  (.clk(clk), .reset(reset), .clear(rise), .inc(a16_inc || a16_dec), .dec(1'b0), .q(asc8));
    sat_counter #(.W(CNT_W)) u_asc16 (.clk(clk), .reset(reset), .clear(rise), .inc(a16_inc), .dec(a16_dec), .q(asc16));
    sat_counter #(.W(CNT_W)) u_kon4  (.clk(clk), .reset(reset), .clear(rise), .inc(k4_inc), .dec(1'b0), .q(kon4));
    sat_counter #(.W(CNT_W)) u_kon5  (.clk(clk), .reset(reset), .clear(rise), .inc(k5_inc), .dec(1'b0), .q(kon5));

    always_comb begin
        map_nx = rom_size < Z8K ? MAP_UNKNOWN :
                 rom_size <= Z64K ? MAP_NONE :
                 (game1 && game2 && rom_size >= GM2_MIN) ? MAP_GM2 :
                 kon > ascii ? (kon5 > kon4 ? MAP_KONAMI_SCC : MAP_KONAMI) :
                 (asc8 > asc16 ? MAP_ASCII8 : MAP_ASCII16);
        off_small = start != 16'h0 ? (start[15:14] == 2'b10 ? 4'd8 : 4'd4) : (h5 == 2'b01 ? 4'd4 : 4'd8);
        off_32k = (!sig0 && sig4 && ((start4k == 16'h0 && h25 == 2'b01) || start4k < 16'h8000 || start4k >= 16'hC000)) ? 4'd0 : 4'd4;
        off_nx = (rom_size == Z4K || rom_size == Z8K || rom_size == Z16K) ? off_small :
                 rom_size == Z32K ? off_32k :
                 rom_size == Z48K ? ((sig0 && !sig4) ? 4'd4 : 4'd0) : 4'd0;
    end

    always_ff @(posedge clk) begin
        load_q <= load;
        if (reset) begin
            state <= S_IDLE;
            valid <= 1'b0;
            mapper <= MAP_UNKNOWN;
            offset <= 4'd0;
            rom_size <= '0;
            prev_addr <= '0;
            win1 <= '0;
            win0 <= '0;
            for (int i = 0; i < 4; i++) begin
                head[i] <= '0;
                head2[i] <= '0;
            end
            {h5, h25, game1, game2, sig0, sig4} <= '0;
            start <= '0;
            start4k <= '0;
            kon <= '0;
            ascii <= '0;
        end else if (rise) begin
            state <= S_LOAD;
            valid <= 1'b0;
            rom_size <= '0;
            prev_addr <= '0;
            win1 <= '0;
            win0 <= '0;
            for (int i = 0; i < 4; i++) begin
                head[i] <= '0;
                head2[i] <= '0;
            end
            {h5, h25, game1, game2} <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (fall)
                        state <= S_EVAL1;
                    if (we) begin
                        prev_addr <= addr;
                        win1 <= contig ? win0 : 8'h00;
                        win0 <= data;
                        if (addr >= rom_size)
                            rom_size <= addr + 1'b1;
                        if (addr[ADDR_W-1:2] == '0)
                            head[addr[1:0]] <= data;
                        if (addr[ADDR_W-1:2] == (ADDR_W-2)'(32'h1000))
                            head2[addr[1:0]] <= data;
                        if (addr == ADDR_W'(32'h5))
                            h5 <= data[7:6];
                        if (addr == ADDR_W'(32'h4005))
                            h25 <= data[7:6];
                        if (addr == ADDR_W'(32'h10) && data == 8'h59)
                            game1 <= 1'b1;
                        if (addr == ADDR_W'(32'h11) && data == 8'h5A)
                            game2 <= 1'b1;
                    end
                end
                S_EVAL1: begin
                    kon <= kon5 > kon4 ? kon5 : kon4;
                    ascii <= asc8 > asc16 ? asc8 : asc16;
                    sig0 <= is_ab(head[0], head[1]);
                    sig4 <= is_ab(head2[0], head2[1]);
                    start <= {head[3], head[2]};
                    start4k <= {head2[3], head2[2]};
                    state <= S_EVAL2;
                end
                S_EVAL2: begin
                    mapper <= map_nx;
                    offset <= off_nx;
                    valid <= 1'b1;
                    state <= S_DONE;
                end
                default: ;
            endcase
        end
    end
endmodule
